// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - FIR filter stream front/back end with bubble tagging and zero flush
module fir_stream_ctrl #(
    parameter int DATAWIDTH    = 64,
    parameter int ORDER        = 41,
    parameter int FILT_LATENCY = 1,
    parameter int CNTWIDTH     = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] InData,
    input  logic                 InValid,
    input  logic                 InLast,
    output logic                 InReady,
    output logic [DATAWIDTH-1:0] FiltIn,
    input  logic [DATAWIDTH-1:0] FiltOut,
    output logic [DATAWIDTH-1:0] OutData,
    output logic                 OutValid,
    output logic                 OutLast,
    output logic                 Busy,
    output logic [CNTWIDTH-1:0]  SampleCount,
    output logic [CNTWIDTH-1:0]  BubbleCount
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  hs;
    logic [DATAWIDTH-1:0]  filt_q, filt_d;
    logic                  tag_v_q, tag_v_d;
    logic                  tag_l_q, tag_l_d;
    logic [FILT_LATENCY-1:0] v_pipe_q, l_pipe_q;
    logic [DATAWIDTH-1:0]  out_data_q;
    logic                  out_valid_q, out_last_q;
    logic [CNTWIDTH-1:0]   samples_q, samples_d;
    logic [CNTWIDTH-1:0]   bubbles_q, bubbles_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts flush zeros in FLUSH and remaining pipeline slots in DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = InLast ? FLUSH : STREAM;
                    cnt_d   = InLast ? ORDER : 32'd0;
                end
            end
            STREAM: begin
                if (hs && InLast) begin
                    state_d = FLUSH;
                    cnt_d   = ORDER;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = DRAIN;
                    cnt_d   = FILT_LATENCY + 1;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    always_comb begin
        InReady   = !Rst && (state_q == IDLE || state_q == STREAM);
        Busy      = (state_q != IDLE);
        hs        = InValid && InReady;
        filt_d    = '0;
        tag_v_d   = 1'b0;
        tag_l_d   = 1'b0;
        samples_d = samples_q;
        bubbles_d = bubbles_q;
        if (hs) begin
            filt_d  = InData;
            tag_v_d = 1'b1;
            if (state_q == IDLE) begin
                samples_d = CNTWIDTH'(1);
                bubbles_d = '0;
            end else if (samples_q != '1) begin
                samples_d = samples_q + CNTWIDTH'(1);
            end
        end else if (state_q == STREAM) begin
            if (bubbles_q != '1) begin
                bubbles_d = bubbles_q + CNTWIDTH'(1);
            end
        end else if (state_q == FLUSH) begin
            tag_v_d = 1'b1;
            tag_l_d = (cnt_q == 32'd1);
        end
    end

    // Tag delay line tracks the filter so OutValid/OutLast line up with FiltOut
    always_ff @(posedge Clk) begin
        if (Rst) begin
            filt_q      <= '0;
            tag_v_q     <= 1'b0;
            tag_l_q     <= 1'b0;
            v_pipe_q    <= '0;
            l_pipe_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            samples_q   <= '0;
            bubbles_q   <= '0;
        end else begin
            filt_q      <= filt_d;
            tag_v_q     <= tag_v_d;
            tag_l_q     <= tag_l_d;
            v_pipe_q[0] <= tag_v_q;
            l_pipe_q[0] <= tag_l_q;
            for (int i = 1; i < FILT_LATENCY; i++) begin
                v_pipe_q[i] <= v_pipe_q[i-1];
                l_pipe_q[i] <= l_pipe_q[i-1];
            end
            out_data_q  <= FiltOut;
            out_valid_q <= v_pipe_q[FILT_LATENCY-1];
            out_last_q  <= l_pipe_q[FILT_LATENCY-1];
            samples_q   <= samples_d;
            bubbles_q   <= bubbles_d;
        end
    end

    assign FiltIn      = filt_q;
    assign OutData     = out_data_q;
    assign OutValid    = out_valid_q;
    assign OutLast     = out_last_q;
    assign SampleCount = samples_q;
    assign BubbleCount = bubbles_q;

endmodule
